// File: rtl/fp_result_wb.sv
// fp_result_wb: two-entry writeback queue for FP64 results with NaN-boxing of
// single-precision values and sticky fflags accumulation at commit.
module fp_result_wb #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [68:0]      res_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             is_single_i,
    input  logic             flush_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [63:0]      wb_data_o,
    output logic [TAG_W-1:0] wb_tag_o,
    input  logic             fflags_we_i,
    input  logic [4:0]       fflags_wdata_i,
    output logic [4:0]       fflags_o
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       cnt_q, cnt_d;
    logic             wr_q, wr_d, rd_q, rd_d;
    logic [63:0]      data_q [DEPTH];
    logic [63:0]      data_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [4:0]       flg_q [DEPTH];
    logic [4:0]       flg_d [DEPTH];
    logic [4:0]       fflags_q, fflags_d, pop_flags;
    logic             push, pop;

    assign ready_o    = cnt_q != FULL;
    assign wb_valid_o = cnt_q != EMPTY;
    assign push       = valid_i & ready_o & ~flush_i;
    assign pop        = wb_valid_o & wb_ready_i;
    assign wb_data_o  = data_q[rd_q];
    assign wb_tag_o   = tag_q[rd_q];
    assign fflags_o   = fflags_q;
    assign pop_flags  = pop ? flg_q[rd_q] : 5'd0;

    always_comb begin
        cnt_d    = flush_i ? EMPTY : cnt_q + 2'(push) - 2'(pop);
        wr_d     = flush_i ? 1'b0 : wr_q ^ push;
        rd_d     = flush_i ? 1'b0 : rd_q ^ pop;
        // a CSR write replaces the sticky bits but must keep the committing entry's flags
        fflags_d = (fflags_we_i ? fflags_wdata_i : fflags_q) | pop_flags;
        data_d   = data_q;
        tag_d    = tag_q;
        flg_d    = flg_q;
        if (push) begin
            data_d[wr_q] = is_single_i ? {32'hFFFF_FFFF, res_i[36:5]} : res_i[68:5];
            tag_d[wr_q]  = tag_i;
            flg_d[wr_q]  = res_i[4:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q    <= EMPTY;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            fflags_q <= 5'd0;
            data_q   <= '{default: '0};
            tag_q    <= '{default: '0};
            flg_q    <= '{default: '0};
        end else begin
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            fflags_q <= fflags_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            flg_q    <= flg_d;
        end
    end
endmodule

// File: doc/fp_result_wb.md
Name: fp_result_wb

Overview:
- Writeback/commit stage directly downstream of the FP64-format conversion and arithmetic units, including the FP32-to-FP64 converter.
- Accepts a rounded result plus exception flags (round_res_t in FP64 format) with a destination tag through a valid/ready handshake.
- Buffers up to two results in a 2-entry queue and presents them to the register-file write port, NaN-boxing single-precision results.
- Accumulates the sticky fflags (NV, DZ, OF, UF, NX) at commit and exposes a CSR read/write path to them.

Parameters:
TAG_W, 5, width of destination register tag
DEPTH, 2, queue entries (fixed at 2; other values unsupported)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
valid_i  in  1  upstream result valid
ready_o  out  1  stage can accept a result this cycle
res_i  in  69  round_res_t (FP64): result[63:0], flags {NV,DZ,OF,UF,NX}[4:0]
tag_i  in  TAG_W  destination register tag
is_single_i  in  1  result is FP32, held in res_i.result[31:0]
flush_i  in  1  discard all queued results
wb_valid_o  out  1  writeback data valid
wb_ready_i  in  1  register file accepts writeback
wb_data_o  out  64  writeback value
wb_tag_o  out  TAG_W  writeback tag
fflags_we_i  in  1  CSR write strobe for fflags
fflags_wdata_i  in  5  CSR write data
fflags_o  out  5  current accumulated fflags

Behaviour:
- One clock domain, clk_i. reset_i is asynchronous and active-high.
- Reset values: queue empty, wb_valid_o=0, wb_data_o=0, wb_tag_o=0, fflags_o=0, ready_o=1 once reset deasserts.
- Entry storage: each entry holds data[63:0], tag, and flags[4:0].
- Data stored at push:
  - is_single_i=1: {32'hFFFF_FFFF, res_i.result[31:0]} (NaN-boxing).
  - is_single_i=0: res_i.result.
- Handshakes:
  - Push when valid_i & ready_o.
  - Pop when wb_valid_o & wb_ready_i.
- Occupancy state machine over a registered count:
  - EMPTY (0): ready_o=1, wb_valid_o=0.
  - ONE (1): ready_o=1, wb_valid_o=1.
  - FULL (2): ready_o=0, wb_valid_o=1.
- Transitions:
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - ONE stays ONE on simultaneous push and pop.
  - FULL -> ONE on pop. No push is possible in FULL.
- ready_o depends only on registered state. There is no combinational path from wb_ready_i to ready_o.
- Ordering and latency:
  - Strict FIFO order using read/write pointers of 1 bit each, wrapping modulo 2.
  - Minimum latency is 1 cycle: a result pushed at edge N is visible on wb_* after edge N.
  - There is no same-cycle bypass.
- wb_data_o and wb_tag_o are driven from the head entry. When empty they hold their last values; the consumer ignores them.
- fflags accumulation:
  - On each pop, fflags <= fflags | head.flags.
  - Flags of flushed entries are never accumulated.
- CSR write:
  - fflags_we_i with no pop in the same cycle: fflags <= fflags_wdata_i.
  - fflags_we_i with a same-cycle pop: fflags <= fflags_wdata_i | head.flags, so the committed instruction's flags are not lost.
- fflags_o is the registered value, i.e. the value after the most recent edge.
- flush_i:
  - Synchronous. Next state is EMPTY and pointers reset to 0.
  - A same-cycle push is dropped.
  - A same-cycle pop still commits, and its flags are accumulated.
  - fflags are otherwise unaffected.
- Asynchronous reset asserted mid-operation: queue contents and fflags cleared immediately. In-flight results are lost.
- No internal flag generation; flags pass through unmodified.

Test Plan:
- Single FP64 push: res_i.result=64'h3FF0_0000_0000_0000, flags=0, tag=3, wb_ready_i=1 -> next cycle wb_valid_o=1, wb_data_o=64'h3FF0000000000000, wb_tag_o=3; EMPTY after pop; fflags_o=0.
- NaN-boxing: is_single_i=1, result[31:0]=32'h3F80_0000 -> wb_data_o=64'hFFFFFFFF_3F800000.
- Backpressure:
  - Stimulus: wb_ready_i=0; push tags 1, 2, 3 on consecutive cycles.
  - Required: ready_o=0 after the 2nd push, and tag 3 is held off.
  - Then wb_ready_i=1 -> pops in order 1, 2, 3; ready_o returns to 1 the cycle after the first pop.
- Flag accumulation:
  - Stimulus: commit flags 5'b00001 (NX), then 5'b10000 (NV).
  - Required: fflags_o=5'b10001.
  - Then CSR write 5'b00000 in the same cycle as a pop carrying 5'b00100 (OF) -> fflags_o=5'b00100.
- Flush: two entries queued with flags 5'b01000 and 5'b00010, wb_ready_i=0, flush_i=1 -> EMPTY next cycle, ready_o=1, fflags_o unchanged.
- Async reset mid-operation: FULL queue with fflags=5'b11111, reset_i pulsed between clock edges -> wb_valid_o=0 and fflags_o=0 immediately, ready_o=1 after deassertion.
